// File: rtl/req_gnt_busy_responder.sv
// req_gnt_busy_responder
// Target-side engine that answers req with a gnt/busy handshake. Each rising
// edge of req is captured, together with a transfer length, into a small
// pending queue. Queued requests are served one at a time: a programmable
// grant delay, a one-cycle gnt pulse, then busy held for the transfer length.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req          request level; a request is a 0->1 transition
//   len          transfer length, sampled with the request edge (0 acts as 1)
//   gnt_dly_cfg  grant delay in cycles, sampled when a request is popped (0 acts as 1)
//   gnt          one-cycle grant pulse
//   busy         high for the duration of the transfer
//   done         one-cycle pulse in the IDLE cycle that follows a transfer
//   pend_cnt     number of queued, not yet popped requests
//   overflow     one-cycle pulse when a request edge was dropped on a full queue
module req_gnt_busy_responder #(
    parameter int PEND_DEPTH = 4,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = $clog2(PEND_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       gnt_dly_cfg,
    output logic             gnt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    localparam int PTR_W = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        BUSY  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               req_q;
    logic [LEN_W-1:0]   mem_q [PEND_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         dcnt_q, dcnt_d;
    logic [LEN_W-1:0]   bcnt_q, bcnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               gnt_q, busy_q, done_q, ovf_q;

    logic               push_edge, full, empty, pop, push;
    logic [LEN_W-1:0]   head_len;

    assign push_edge = req & ~req_q;
    assign full      = (cnt_q == CNT_W'(PEND_DEPTH));
    assign empty     = (cnt_q == '0);
    assign pop       = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push on a full queue still lands.
    assign push      = push_edge && (!full || pop);
    assign head_len  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        bcnt_d  = bcnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    len_d   = (head_len == '0) ? LEN_W'(1) : head_len;
                    // Effective delay D = max(cfg,1); WAIT lasts D cycles.
                    dcnt_d  = (gnt_dly_cfg == 2'd0) ? 2'd0 : gnt_dly_cfg - 2'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dcnt_q == 2'd0) state_d = GRANT;
                else                dcnt_d  = dcnt_q - 2'd1;
            end
            GRANT: begin
                bcnt_d  = len_q - LEN_W'(1);
                state_d = BUSY;
            end
            BUSY: begin
                if (bcnt_q == '0) state_d = IDLE;
                else              bcnt_d  = bcnt_q - LEN_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            len_q   <= '0;
            gnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            // Outputs are registered copies of the state being entered, so
            // they line up with the state they describe.
            gnt_q   <= (state_d == GRANT);
            busy_q  <= (state_d == BUSY);
            done_q  <= (state_q == BUSY) && (state_d == IDLE);
            ovf_q   <= push_edge && full && !pop;
        end
    end

    // ------------------------------------------------------------------
    // Pending queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Queue storage carries no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= len;
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign pend_cnt = cnt_q;

endmodule

// File: doc/req_gnt_busy_responder.md
Name: req_gnt_busy_responder

Overview:
- Target-side protocol engine that generates the gnt/busy handshake in response to req.
- Sits directly downstream of the requester and drives the req/gnt/busy signals that the protocol assertion checker monitors.
- Captures request edges together with a transfer length into a small pending queue.
- Serves queued requests one at a time: programmable grant delay (1..3 cycles), a one-cycle gnt pulse, then busy held for the transfer length.

Parameters:
- PEND_DEPTH, 4, pending-request queue depth (power of two, >=2)
- LEN_W, 4, width of transfer-length field
- CNT_W, $clog2(PEND_DEPTH+1), width of pend_cnt

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request from requester; a new request = rising edge (req high, registered req_q low)
- len  in  LEN_W  busy length, sampled on the req rising-edge cycle
- gnt_dly_cfg  in  2  grant delay in cycles, sampled at queue pop; 0 treated as 1
- gnt  out  1  one-cycle grant pulse, registered
- busy  out  1  transfer in progress, registered
- done  out  1  one-cycle pulse on return to IDLE after a transfer, registered
- pend_cnt  out  CNT_W  number of queued, not-yet-popped requests
- overflow  out  1  one-cycle pulse: a request edge was dropped because the queue was full

Behaviour:
- Reset (async assert, sync release): state IDLE; queue empty; req_q=0; gnt=busy=done=overflow=0; pend_cnt=0. Asserting rst mid-transfer drops gnt/busy immediately; queued requests are discarded.
- Edge capture: the cycle with req=1, req_q=0 is a request edge at sample edge N.
  - Pushes {len} into the queue.
  - A level-held req produces one request only.
- Push when full:
  - Dropped, with overflow=1 for one cycle, unless a pop occurs at the same edge; a simultaneous push+pop on full succeeds.
  - pend_cnt is unchanged on a simultaneous push+pop.
- States: IDLE, WAIT, GRANT, BUSY.
  - IDLE: queue non-empty -> pop; latch len (len 0 -> 1); load dcnt = max(gnt_dly_cfg,1)-1; go to WAIT.
  - WAIT: dcnt==0 -> GRANT; else dcnt--.
  - GRANT: gnt=1 for exactly this cycle; load bcnt=len-1; go to BUSY.
  - BUSY: busy=1; bcnt==0 -> IDLE with done=1 in the next cycle (the IDLE cycle); else bcnt--.
- Latency: request edge at sample edge N with queue empty and FSM in IDLE -> gnt high in cycle N+D+1 (D = effective delay) -> busy high in cycles N+D+2 .. N+D+1+len.
- Back-to-back requests: after done, IDLE pops the next entry in the same cycle done is high. There is a minimum of one IDLE cycle between busy low and the next WAIT.
- gnt and busy are never high together. gnt rises only from WAIT and is always low in the cycle before.
- A req edge while the FSM is busy is queued normally. req level is ignored by the FSM otherwise; the requester is not required to hold req.
- pend_cnt: +1 on push, -1 on pop, unchanged on both or neither. Queue pointers wrap modulo PEND_DEPTH.
- Config changes to gnt_dly_cfg outside the pop cycle have no effect on the in-flight request.

Test Plan:
- Reset: hold rst for 3 cycles, then release -> gnt=busy=done=overflow=0 and pend_cnt=0. Assert rst while busy=1 -> busy=0 before the next clk edge.
- Single request: gnt_dly_cfg=2, len=3, req rises at edge 10 -> gnt high in cycle 13 only; busy high in cycles 14-16; done in cycle 17; pend_cnt 1 during cycle 10, back to 0 at cycle 11.
- Delay sweep: gnt_dly_cfg in {0,1,2,3} with len=1 -> gnt in cycles N+2, N+2, N+3, N+4; gnt_dly_cfg=0 behaves exactly as 1.
- Level hold and back-to-back:
  - req held high for 20 cycles -> exactly one grant.
  - Two edges 2 cycles apart, len=2, D=1 -> second gnt exactly 2 cycles after the first transfer's done cycle.
  - gnt and busy never overlap.
- Overflow: 5 request edges with PEND_DEPTH=4 while the FSM sits in a long BUSY (len=15) -> 5th edge: overflow pulse, pend_cnt stays 4; exactly 4 more grants follow.
- Full push+pop: queue full and FSM enters IDLE in the same cycle as a new req edge -> no overflow, pend_cnt stays 4, all 5 requests are eventually granted in order.
